control_filtro_bandas: RTL and testbench
========================================

# control_filtro_bandas

Sequencer for the shared low-pass biquad datapath (`Filtro_Paso_Bajos` family). Per input sample, it steps the coefficient/state mux select through the high, mid and low bands. It pulses the matching band state-register enable exactly once per band and captures the filter output into per-band result registers. The block sits between the sample source (ADC/interface at the 150 kHz domain) and the filter datapath. It owns `Sel_Muxes`, `enable1..3` and the stable `uk` presented to the filter.

## Interface
- `Width`, 22 — sample and coefficient word width (signed fixed point, same as the datapath).
- `SettleCycles`, 2 — cycles allowed for the combinational multiply/add path to settle after a select change; legal range 1..15.
- `clk150kHz` in 1 — single clock; all state changes on the rising edge.
- `reset` in 1 — asynchronous, active-high; clears all state and outputs.
- `sample_valid` in 1 — one-cycle strobe; `uk_in` carries a new sample.
- `uk_in` in Width, signed — incoming sample.
- `band_mask` in 3 — bit0 high band, bit1 mid, bit2 low; 1 = process that band. Sampled at acceptance.
- `filtro_out` in Width, signed — datapath output (`Conex_Bajos`).
- `uk` out Width, signed — held sample driven to the datapath.
- `Sel_Muxes` out 2 — band select: 00 high, 01 mid, 10 low; 11 never driven.
- `enable1` / `enable2` / `enable3` out 1 each — high/mid/low band state-register enables.
- `y_altas` / `y_medias` / `y_bajas` out Width, signed — latest captured band outputs.
- `valid_out` out 1 — one-cycle pulse; results of the current sample are complete.
- `busy` out 1 — high in every state except IDLE.
- `overrun` out 1 — sticky; set when a sample is dropped.
- `overrun_cnt` out 8 — saturating count of dropped samples.

## Operation
- States: IDLE, SETTLE, CAPTURE, DONE.
- **IDLE**
  - On `sample_valid`: latch `uk_in` into `uk` and latch `band_mask`.
  - If the latched mask ≠ 0, go to SETTLE with `Sel_Muxes` set to the lowest-index enabled band and the settle counter loaded with SettleCycles.
  - If the mask = 0, go straight to DONE.
- **SETTLE**
  - Hold `Sel_Muxes` and `uk`; decrement the counter.
  - When the counter reaches its terminal value (SettleCycles cycles spent here), go to CAPTURE.
- **CAPTURE** (exactly one cycle)
  - Assert only the enable of the current band.
  - On the same edge, load `filtro_out` into that band's result register. The datapath state register and the result register sample the same settled values.
  - If a higher-index enabled band remains, update `Sel_Muxes` to it, reload the counter and go to SETTLE.
  - Otherwise go to DONE.
- **DONE**
  - `valid_out` = 1 for one cycle, then go to IDLE.
- Masked bands:
  - Their enable never pulses.
  - Their result register holds its previous value.
- Overrun: `sample_valid` in any state other than IDLE:
  - The sample is dropped; `uk` and the sequence are unaffected.
  - `overrun` is set.
  - `overrun_cnt` increments, saturating at 255.
- `Sel_Muxes` holds its last value in IDLE and DONE.
- At most one of `enable1..3` is ever high.
- No arithmetic in this block; result registers are pure Width-bit copies, with no rounding or saturation.

## Timing
- Reset values:
  - state IDLE.
  - `uk`, `y_*`, `Sel_Muxes` = 0.
  - `enable1..3`, `valid_out`, `busy`, `overrun` = 0.
  - `overrun_cnt` = 0.
- Cycle timeline, with acceptance edge = cycle 0 and S = SettleCycles:
  - SETTLE for band k spans cycles 1+k(S+1) .. S+k(S+1).
  - CAPTURE for band k is in cycle (k+1)(S+1).
  - Here k counts enabled bands in order.
- With N enabled bands:
  - `valid_out` is high in cycle N(S+1)+1.
  - `busy` is high from cycle 1 through cycle N(S+1)+1.
  - IDLE is reached in cycle N(S+1)+2.
- Mask = 0: DONE in cycle 1, with no enables.
- Default S=2 with all bands: `valid_out` in cycle 10, so the minimum sample spacing is 11 cycles.
- `sample_valid` coincident with DONE counts as overrun.
- Reset asserted mid-sequence:
  - Immediate return to IDLE with reset values.
  - A partially completed sample produces no `valid_out`.
  - The datapath registers are cleared by the same reset.

## Test plan
- Reset, then `uk_in` = 22'h000400 with mask 3'b111 and S=2:
  - `enable1` high in cycle 3 (Sel 00), `enable2` in cycle 6 (Sel 01), `enable3` in cycle 9 (Sel 10).
  - `valid_out` in cycle 10.
  - Each `y_*` equals the `filtro_out` value driven during its CAPTURE cycle.
- Mask 3'b100:
  - Sel 10 from cycle 1; `enable3` only, in cycle 3.
  - `valid_out` in cycle 4; `y_altas`/`y_medias` unchanged.
- Mask 3'b000: `valid_out` in cycle 1, no enable pulses, `busy` high only in cycle 1.
- `sample_valid` in cycles 0, 5 and 10 (full mask):
  - Samples at cycles 5 and 10 are dropped, with `uk` still holding the first value.
  - `overrun` = 1 and `overrun_cnt` = 2.
  - 300 further overrun strobes leave `overrun_cnt` at 255.
- `reset` asserted in cycle 4 of a full-mask sequence:
  - Outputs return to their reset values immediately.
  - No `valid_out`.
  - A new sample afterwards completes normally with `valid_out` at cycle 10.

Source files
------------

// File: rtl/control_filtro_bandas.sv
// rtl/control_filtro_bandas.sv - band sequencer for the shared low-pass biquad datapath
module control_filtro_bandas #(
    parameter int Width        = 22,
    parameter int SettleCycles = 2
) (
    input  logic                    clk150kHz,
    input  logic                    reset,
    input  logic                    sample_valid,
    input  logic signed [Width-1:0] uk_in,
    input  logic [2:0]              band_mask,
    input  logic signed [Width-1:0] filtro_out,
    output logic signed [Width-1:0] uk,
    output logic [1:0]              Sel_Muxes,
    output logic                    enable1,
    output logic                    enable2,
    output logic                    enable3,
    output logic signed [Width-1:0] y_altas,
    output logic signed [Width-1:0] y_medias,
    output logic signed [Width-1:0] y_bajas,
    output logic                    valid_out,
    output logic                    busy,
    output logic                    overrun,
    output logic [7:0]              overrun_cnt
);

    typedef enum logic [1:0] {IDLE, SETTLE, CAPTURE, DONE} state_t;

    localparam logic [3:0] SETTLE_LOAD = 4'(SettleCycles);

    state_t     state, state_next;
    logic [3:0] cnt, cnt_next;
    logic [1:0] sel_next;
    logic [2:1] mask_hi;
    logic [1:0] first_band, next_band;
    logic       has_first, has_next;

    // Band 0 needs no latched bit: it can only ever be the first band.
    always_comb begin
        has_first  = |band_mask;
        first_band = band_mask[0] ? 2'd0 : (band_mask[1] ? 2'd1 : 2'd2);
        has_next   = 1'b0;
        next_band  = Sel_Muxes;
        case (Sel_Muxes)
            2'd0: begin
                if (mask_hi[1]) begin
                    has_next  = 1'b1;
                    next_band = 2'd1;
                end else if (mask_hi[2]) begin
                    has_next  = 1'b1;
                    next_band = 2'd2;
                end
            end
            2'd1: begin
                if (mask_hi[2]) begin
                    has_next  = 1'b1;
                    next_band = 2'd2;
                end
            end
            default: ;
        endcase
    end

    always_comb begin
        state_next = state;
        sel_next   = Sel_Muxes;
        cnt_next   = cnt;
        case (state)
            IDLE: begin
                if (sample_valid) begin
                    if (has_first) begin
                        state_next = SETTLE;
                        sel_next   = first_band;
                        cnt_next   = SETTLE_LOAD;
                    end else begin
                        state_next = DONE;
                    end
                end
            end
            SETTLE: begin
                cnt_next = cnt - 4'd1;
                if (cnt == 4'd1) state_next = CAPTURE;
            end
            CAPTURE: begin
                if (has_next) begin
                    state_next = SETTLE;
                    sel_next   = next_band;
                    cnt_next   = SETTLE_LOAD;
                end else begin
                    state_next = DONE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    assign enable1   = (state == CAPTURE) && (Sel_Muxes == 2'd0);
    assign enable2   = (state == CAPTURE) && (Sel_Muxes == 2'd1);
    assign enable3   = (state == CAPTURE) && (Sel_Muxes == 2'd2);
    assign valid_out = (state == DONE);
    assign busy      = (state != IDLE);

    always_ff @(posedge clk150kHz or posedge reset) begin
        if (reset) begin
            state       <= IDLE;
            Sel_Muxes   <= 2'd0;
            cnt         <= 4'd0;
            mask_hi     <= 2'b00;
            uk          <= '0;
            y_altas     <= '0;
            y_medias    <= '0;
            y_bajas     <= '0;
            overrun     <= 1'b0;
            overrun_cnt <= 8'd0;
        end else begin
            state     <= state_next;
            Sel_Muxes <= sel_next;
            cnt       <= cnt_next;
            if (state == IDLE && sample_valid) begin
                uk      <= uk_in;
                mask_hi <= band_mask[2:1];
            end
            // Result register samples on the same edge as the datapath state enable.
            if (state == CAPTURE) begin
                case (Sel_Muxes)
                    2'd0:    y_altas  <= filtro_out;
                    2'd1:    y_medias <= filtro_out;
                    2'd2:    y_bajas  <= filtro_out;
                    default: ;
                endcase
            end
            if (sample_valid && state != IDLE) begin
                overrun <= 1'b1;
                if (overrun_cnt != 8'hFF) overrun_cnt <= overrun_cnt + 8'd1;
            end
        end
    end

endmodule

// File: tb/tb_control_filtro_bandas.sv
// tb/tb_control_filtro_bandas.sv - directed self-checking bench for control_filtro_bandas
module tb_control_filtro_bandas;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        sample_valid = 1'b0;
    logic [21:0] uk_in = '0;
    logic [2:0]  band_mask = '0;
    logic [21:0] filtro_out = '0;
    logic [21:0] uk, y_altas, y_medias, y_bajas;
    logic [1:0]  Sel_Muxes;
    logic        enable1, enable2, enable3, valid_out, busy, overrun;
    logic [7:0]  overrun_cnt;

    int checks = 0;
    int errors = 0;

    logic [2:0]  en_r   [0:15];
    logic [1:0]  sel_r  [0:15];
    logic        vld_r  [0:15];
    logic        busy_r [0:15];
    logic [21:0] fbase;

    control_filtro_bandas #(.Width(22), .SettleCycles(2)) dut (
        .clk150kHz   (clk),
        .reset       (reset),
        .sample_valid(sample_valid),
        .uk_in       (uk_in),
        .band_mask   (band_mask),
        .filtro_out  (filtro_out),
        .uk          (uk),
        .Sel_Muxes   (Sel_Muxes),
        .enable1     (enable1),
        .enable2     (enable2),
        .enable3     (enable3),
        .y_altas     (y_altas),
        .y_medias    (y_medias),
        .y_bajas     (y_bajas),
        .valid_out   (valid_out),
        .busy        (busy),
        .overrun     (overrun),
        .overrun_cnt (overrun_cnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Called just after a rising edge; the next edge is acceptance (cycle 0).
    task automatic run(input logic [2:0] m, input logic [21:0] d, input int n,
                       input logic [15:0] ovr);
        int viol;
        sample_valid = 1'b1;
        uk_in        = d;
        band_mask    = m;
        @(posedge clk); #1;
        sample_valid = 1'b0;
        band_mask    = 3'b000;
        uk_in        = 22'h2AAAAA;
        viol         = 0;
        for (int c = 1; c <= n; c++) begin
            en_r[c]   = {enable3, enable2, enable1};
            sel_r[c]  = Sel_Muxes;
            vld_r[c]  = valid_out;
            busy_r[c] = busy;
            if ($countones({enable3, enable2, enable1}) > 1) viol++;
            filtro_out   = fbase + 22'(c);
            sample_valid = ovr[c];
            uk_in        = ovr[c] ? 22'h3FFFFF : 22'h2AAAAA;
            @(posedge clk); #1;
        end
        sample_valid = 1'b0;
        check("enables_onehot0", viol, 0);
    endtask

    initial begin
        #3;
        check("rst_uk", uk, 0);
        check("rst_sel", Sel_Muxes, 0);
        check("rst_flags", {enable1, enable2, enable3, valid_out, busy, overrun}, 0);
        check("rst_ocnt", overrun_cnt, 0);
        check("rst_y", {y_altas, y_medias, y_bajas}, 0);
        #9 reset = 1'b0;
        @(posedge clk); #1;

        fbase = 22'h0A0000;
        run(3'b111, 22'h000400, 12, 16'h0000);
        check("full_en_c3", en_r[3], 3'b001);
        check("full_sel_c3", sel_r[3], 2'b00);
        check("full_en_c6", en_r[6], 3'b010);
        check("full_sel_c6", sel_r[6], 2'b01);
        check("full_en_c9", en_r[9], 3'b100);
        check("full_sel_c9", sel_r[9], 2'b10);
        check("full_en_c2", en_r[2], 3'b000);
        check("full_vld_c9", vld_r[9], 0);
        check("full_vld_c10", vld_r[10], 1);
        check("full_vld_c11", vld_r[11], 0);
        check("full_busy_c1", busy_r[1], 1);
        check("full_busy_c10", busy_r[10], 1);
        check("full_busy_c11", busy_r[11], 0);
        check("full_uk", uk, 22'h000400);
        check("full_y_altas", y_altas, 22'h0A0003);
        check("full_y_medias", y_medias, 22'h0A0006);
        check("full_y_bajas", y_bajas, 22'h0A0009);
        check("full_sel_idle", sel_r[11], 2'b10);

        fbase = 22'h150000;
        run(3'b100, 22'h000055, 6, 16'h0000);
        check("low_sel_c1", sel_r[1], 2'b10);
        check("low_en_c3", en_r[3], 3'b100);
        check("low_vld_c4", vld_r[4], 1);
        check("low_vld_c3", vld_r[3], 0);
        check("low_busy_c5", busy_r[5], 0);
        check("low_y_bajas", y_bajas, 22'h150003);
        check("low_y_altas", y_altas, 22'h0A0003);
        check("low_y_medias", y_medias, 22'h0A0006);

        fbase = 22'h1F0000;
        run(3'b000, 22'h000077, 4, 16'h0000);
        check("zero_vld_c1", vld_r[1], 1);
        check("zero_busy_c1", busy_r[1], 1);
        check("zero_busy_c2", busy_r[2], 0);
        check("zero_en", {en_r[1], en_r[2], en_r[3]}, 0);
        check("zero_y", {y_altas, y_medias, y_bajas}, {22'h0A0003, 22'h0A0006, 22'h150003});
        check("zero_ovr", {overrun, overrun_cnt}, 0);

        fbase = 22'h030000;
        run(3'b111, 22'h000123, 12, 16'h0420);
        check("ovr_uk", uk, 22'h000123);
        check("ovr_flag", overrun, 1);
        check("ovr_cnt", overrun_cnt, 2);
        check("ovr_vld_c10", vld_r[10], 1);
        check("ovr_en_c9", en_r[9], 3'b100);
        check("ovr_y_bajas", y_bajas, 22'h030009);

        sample_valid = 1'b1;
        uk_in        = 22'h000321;
        band_mask    = 3'b111;
        repeat (330) @(posedge clk);
        #1 sample_valid = 1'b0;
        repeat (15) @(posedge clk);
        #1;
        check("sat_cnt", overrun_cnt, 255);
        check("sat_idle", busy, 0);

        fbase = 22'h040000;
        sample_valid = 1'b1;
        uk_in        = 22'h000456;
        band_mask    = 3'b111;
        @(posedge clk); #1;
        sample_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1 reset = 1'b1;
        #1;
        check("mrst_flags", {enable1, enable2, enable3, valid_out, busy, overrun}, 0);
        check("mrst_regs", {uk, Sel_Muxes, y_altas}, 0);
        check("mrst_ocnt", overrun_cnt, 0);
        @(posedge clk); #1 reset = 1'b0;
        begin
            int vcount = 0;
            for (int c = 0; c < 14; c++) begin
                if (valid_out) vcount++;
                @(posedge clk); #1;
            end
            check("mrst_no_valid", vcount, 0);
        end
        run(3'b111, 22'h000789, 12, 16'h0000);
        check("post_vld_c10", vld_r[10], 1);
        check("post_vld_c9", vld_r[9], 0);
        check("post_uk", uk, 22'h000789);
        check("post_y_medias", y_medias, 22'h040006);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
